// File: rtl/mono_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mono_tx_pkg
// Description : Shared constants and helpers for the MONOPIX readout
//               transmitter emulator: hit field widths, serial word width,
//               FSM state encodings, bit-counter width and the word packer.
// Revision    : 1.0 - initial release
// ============================================================================
package mono_tx_pkg;

    localparam int COL_W     = 6;
    localparam int ROW_W     = 8;
    localparam int TS_W      = 6;
    localparam int WORD_W    = COL_W + ROW_W + TS_W + TS_W;   // 26
    localparam int BIT_CNT_W = 5;

    // Transmit FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    // Serial word layout: {COL, ROW, LE, TE}, MSB transmitted first
    function automatic logic [WORD_W-1:0] pack_hit(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row,
        input logic [TS_W-1:0]  le,
        input logic [TS_W-1:0]  te
    );
        return {col, row, le, te};
    endfunction

endpackage : mono_tx_pkg
`default_nettype wire

// File: rtl/mono_hit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mono_hit_fifo
// Description : Synchronous show-ahead FIFO with registered full/empty flags.
//               Pointers carry one extra MSB so full and empty can be told
//               apart when the address bits match after wrap-around.
// Ports       : CLK, nRST (sync, active-low)
//               i_wr_en/i_wr_data  - push (ignored while full)
//               i_rd_en            - pop  (ignored while empty)
//               o_rd_data          - current head, valid while !o_empty
//               o_full/o_empty     - registered status flags
// Revision    : 1.0 - initial release
// ============================================================================
module mono_hit_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [c_aw:0]    w_wptr_nxt;
    logic [c_aw:0]    w_rptr_nxt;

    assign w_push     = i_wr_en & ~r_full;
    assign w_pop      = i_rd_en & ~r_empty;
    assign w_wptr_nxt = r_wptr + {{c_aw{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{c_aw{1'b0}}, w_pop};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[c_aw-1:0] == w_rptr_nxt[c_aw-1:0]) &&
                       (w_wptr_nxt[c_aw] != w_rptr_nxt[c_aw]);
        end
    end

    // Storage needs no reset: the flushed pointers make old contents unreachable
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rptr[c_aw-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule : mono_hit_fifo
`default_nettype wire

// File: rtl/mono_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : mono_data_tx
// Description : MONOPIX readout periphery emulator. Hits are buffered in a
//               FIFO; TOKEN advertises stored data; each READ rising edge
//               sends one 26-bit word MSB-first on DATA. FREEZE blocks hit
//               acceptance only.
// Ports       : CLK, nRST (sync, active-low)
//               HIT_WRITE, HIT_COL, HIT_ROW, HIT_LE, HIT_TE - hit load port
//               READ, FREEZE                               - receiver control
//               TOKEN, DATA, BUSY                          - readout outputs
//               LOST_CNT (saturating), READ_ERR (1-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module mono_data_tx
    import mono_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LOST_BITS  = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 HIT_WRITE,
    input  logic [COL_W-1:0]     HIT_COL,
    input  logic [ROW_W-1:0]     HIT_ROW,
    input  logic [TS_W-1:0]      HIT_LE,
    input  logic [TS_W-1:0]      HIT_TE,
    input  logic                 READ,
    input  logic                 FREEZE,
    output logic                 TOKEN,
    output logic                 DATA,
    output logic                 BUSY,
    output logic [LOST_BITS-1:0] LOST_CNT,
    output logic                 READ_ERR
);

    localparam logic [BIT_CNT_W-1:0] c_last_bit = BIT_CNT_W'(WORD_W - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_read_q;
    logic                 r_read_qq;
    logic                 w_read_edge;
    logic [WORD_W-1:0]    r_sreg;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [LOST_BITS-1:0] r_lost_cnt;
    logic                 r_token;
    logic                 r_read_err;

    logic [WORD_W-1:0]    w_hit_word;
    logic [WORD_W-1:0]    w_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_busy;
    logic                 w_data;

    assign w_hit_word = pack_hit(HIT_COL, HIT_ROW, HIT_LE, HIT_TE);

    // "full" is the registered flag, so a push coinciding with a pop from a
    // full FIFO is still rejected and counted as lost.
    assign w_drop = HIT_WRITE & (FREEZE | w_fifo_full);

    mono_hit_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_wr_en   (HIT_WRITE & ~FREEZE),
        .i_wr_data (w_hit_word),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_read_edge = r_read_q & ~r_read_qq;
    assign w_pop       = (r_state == IDLE) & w_read_edge & ~w_fifo_empty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT:   if (r_bit_cnt == c_last_bit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy = 1'b0;
        w_data = 1'b0;
        case (r_state)
            LOAD:  w_busy = 1'b1;
            SHIFT: begin
                w_busy = 1'b1;
                w_data = r_sreg[WORD_W-1];
            end
            default: begin
                w_busy = 1'b0;
                w_data = 1'b0;
            end
        endcase
    end

    // The head is captured on the pop edge because the show-ahead output
    // moves to the next entry in the same cycle; LOAD then only clears
    // the bit counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_sreg <= w_head;
            end else if (r_state == SHIFT) begin
                r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
            end
            if (r_state == LOAD) begin
                r_bit_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    // READ synchroniser/edge detector, status and error registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_read_q   <= 1'b0;
            r_read_qq  <= 1'b0;
            r_token    <= 1'b0;
            r_read_err <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            r_read_q   <= READ;
            r_read_qq  <= r_read_q;
            r_token    <= ~w_fifo_empty;
            r_read_err <= w_read_edge & ~w_pop;
            if (w_drop && (r_lost_cnt != {LOST_BITS{1'b1}})) begin
                r_lost_cnt <= r_lost_cnt + {{(LOST_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    assign TOKEN    = r_token;
    assign DATA     = w_data;
    assign BUSY     = w_busy;
    assign LOST_CNT = r_lost_cnt;
    assign READ_ERR = r_read_err;

endmodule : mono_data_tx
`default_nettype wire

// File: tb/tb_mono_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mono_data_tx
// Description : Self-checking bench for mono_data_tx. A cycle reference model
//               predicts TOKEN/BUSY/LOST_CNT/READ_ERR; popped words go to a
//               scoreboard queue and are compared when DATA completes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mono_data_tx;
    import mono_tx_pkg::*;

    localparam int DEPTH = 16;
    localparam int LBITS = 8;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             HIT_WRITE = 1'b0;
    logic [COL_W-1:0] HIT_COL = '0;
    logic [ROW_W-1:0] HIT_ROW = '0;
    logic [TS_W-1:0]  HIT_LE = '0;
    logic [TS_W-1:0]  HIT_TE = '0;
    logic             READ = 1'b0;
    logic             FREEZE = 1'b0;
    logic             TOKEN;
    logic             DATA;
    logic             BUSY;
    logic [LBITS-1:0] LOST_CNT;
    logic             READ_ERR;

    always #5 CLK = ~CLK;

    mono_data_tx #(
        .FIFO_DEPTH (DEPTH),
        .LOST_BITS  (LBITS)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .HIT_WRITE (HIT_WRITE),
        .HIT_COL   (HIT_COL),
        .HIT_ROW   (HIT_ROW),
        .HIT_LE    (HIT_LE),
        .HIT_TE    (HIT_TE),
        .READ      (READ),
        .FREEZE    (FREEZE),
        .TOKEN     (TOKEN),
        .DATA      (DATA),
        .BUSY      (BUSY),
        .LOST_CNT  (LOST_CNT),
        .READ_ERR  (READ_ERR)
    );

    // ---------------- reference model state ----------------
    logic [WORD_W-1:0] mq[$];     // expected FIFO contents
    logic [WORD_W-1:0] tx_q[$];   // words popped, awaiting serial output
    logic [WORD_W-1:0] acc;
    int                m_busy;    // remaining BUSY cycles
    int                m_lost;
    bit                m_rq, m_rqq;
    bit                e_tok, e_err;
    int                errors = 0;
    int                checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive on negedge, advance model at posedge, sample 1 ns later
    task automatic step(input bit rst_n, input bit hw, input bit rd, input bit frz,
                        input logic [WORD_W-1:0] w);
        int occ;
        bit rd_edge, accept, pop;
        @(negedge CLK);
        nRST = rst_n; HIT_WRITE = hw; READ = rd; FREEZE = frz;
        {HIT_COL, HIT_ROW, HIT_LE, HIT_TE} = w;
        @(posedge CLK);
        if (!rst_n) begin
            mq.delete(); tx_q.delete();
            m_busy = 0; m_lost = 0; m_rq = 0; m_rqq = 0; e_tok = 0; e_err = 0;
        end else begin
            occ     = mq.size();
            rd_edge = m_rq & ~m_rqq;
            e_tok   = (occ > 0);
            accept  = hw & ~frz & (occ < DEPTH);
            pop     = rd_edge && (m_busy == 0) && (occ > 0);
            e_err   = rd_edge & ~pop;
            if (m_busy > 0) m_busy--;
            if (pop) begin
                tx_q.push_back(mq.pop_front());
                m_busy = 27;
            end
            if (accept) mq.push_back(w);
            else if (hw && m_lost < 255) m_lost++;
            m_rqq = m_rq;
            m_rq  = rd;
        end
        #1;
        chk("token", {31'b0, TOKEN}, {31'b0, e_tok});
        chk("busy", {31'b0, BUSY}, (m_busy > 0) ? 32'd1 : 32'd0);
        chk("lost_cnt", {24'b0, LOST_CNT}, m_lost);
        chk("read_err", {31'b0, READ_ERR}, {31'b0, e_err});
        if (m_busy == 0 || m_busy == 27) begin
            chk("data_idle", {31'b0, DATA}, 32'd0);
        end else begin
            acc = {acc[WORD_W-2:0], DATA};
            if (m_busy == 1) begin
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL word: got=%0h expected=no word in flight", acc);
                end else begin
                    chk("word", {6'b0, acc}, {6'b0, tx_q.pop_front()});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0);
    endtask

    task automatic write(input logic [WORD_W-1:0] w);
        step(1, 1, 0, 0, w);
    endtask

    task automatic read_word();
        step(1, 0, 1, 0, '0);
        idle(29);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);
    endtask

    function automatic logic [WORD_W-1:0] rnd_word();
        return WORD_W'($urandom);
    endfunction

    typedef struct {
        bit                hw;
        bit                frz;
        logic [WORD_W-1:0] w;
        bit                exp_tok;
        logic [LBITS-1:0]  exp_lost;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [WORD_W-1:0] w1;
        w1 = pack_hit(6'd5, 8'h81, 6'h12, 6'h2A);

        // Reset state
        do_reset();
        chk("rst_token", {31'b0, TOKEN}, 0);
        chk("rst_data", {31'b0, DATA}, 0);
        chk("rst_busy", {31'b0, BUSY}, 0);
        chk("rst_lost", {24'b0, LOST_CNT}, 0);
        chk("rst_err", {31'b0, READ_ERR}, 0);

        // Single hit then frozen writes: table of inputs/expected TOKEN, LOST_CNT
        tbl[0] = '{1, 0, w1,          0, 8'd0};
        tbl[1] = '{0, 0, '0,          1, 8'd0};
        tbl[2] = '{1, 1, 26'h3FFFFFF, 1, 8'd1};
        tbl[3] = '{1, 1, 26'h1234567, 1, 8'd2};
        tbl[4] = '{1, 1, 26'h0ABCDEF, 1, 8'd3};
        tbl[5] = '{1, 1, 26'h2222222, 1, 8'd4};
        tbl[6] = '{0, 0, '0,          1, 8'd4};
        for (int i = 0; i < 7; i++) begin
            step(1, tbl[i].hw, 0, tbl[i].frz, tbl[i].w);
            chk($sformatf("tbl%0d_token", i), {31'b0, TOKEN}, {31'b0, tbl[i].exp_tok});
            chk($sformatf("tbl%0d_lost", i), {24'b0, LOST_CNT}, {24'b0, tbl[i].exp_lost});
        end
        read_word();        // only w1 was stored
        read_word();        // FIFO empty: READ_ERR, no data

        // Fill 16, overflow 3, drain in order, 17th read errors
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) write(rnd_word());
        idle(1);
        chk("lost_overflow", {24'b0, LOST_CNT}, 3);
        for (int i = 0; i < DEPTH + 1; i++) read_word();

        // READ held high for 40 cycles sends exactly one word
        do_reset();
        write(rnd_word()); write(rnd_word()); idle(2);
        for (int i = 0; i < 40; i++) step(1, 0, 1, 0, '0);
        idle(3);
        chk("held_read_token", {31'b0, TOKEN}, 1);
        read_word();

        // Second READ edge mid-word
        do_reset();
        write(rnd_word()); write(rnd_word()); idle(2);
        step(1, 0, 1, 0, '0);
        idle(9);
        step(1, 0, 1, 0, '0);
        idle(25);
        read_word();

        // Push and pop in the same cycle at occupancy 1
        do_reset();
        write(rnd_word()); idle(2);
        step(1, 0, 1, 0, '0);
        step(1, 1, 0, 0, rnd_word());   // pop edge
        idle(3);
        chk("pushpop1_token", {31'b0, TOKEN}, 1);
        idle(26);
        read_word();
        read_word();

        // Push and pop in the same cycle when full: push dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) write(rnd_word());
        idle(1);
        step(1, 0, 1, 0, '0);
        step(1, 1, 0, 0, rnd_word());   // pop edge
        chk("pushpop_full_lost", {24'b0, LOST_CNT}, 1);
        idle(28);
        for (int i = 0; i < DEPTH; i++) read_word();

        // Reset in the middle of a word
        do_reset();
        write(rnd_word()); write(rnd_word()); idle(2);
        step(1, 0, 1, 0, '0);
        idle(17);
        step(0, 0, 0, 0, '0);
        chk("midrst_data", {31'b0, DATA}, 0);
        chk("midrst_busy", {31'b0, BUSY}, 0);
        chk("midrst_token", {31'b0, TOKEN}, 0);
        idle(2);
        read_word();

        // LOST_CNT saturation
        do_reset();
        for (int i = 0; i < 260; i++) step(1, 1, 0, 1, rnd_word());
        chk("lost_saturate", {24'b0, LOST_CNT}, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mono_data_tx
`default_nettype wire
